// File: rtl/pong_pkg.sv
// Shared Pong definitions: direction encoding, request decode, screen and colour constants.
package pong_pkg;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    localparam int SCREEN_X = 640;
    localparam int SCREEN_Y = 480;

    localparam logic [2:0] COLOR_BLACK = 3'b000;
    localparam logic [2:0] COLOR_BLUE  = 3'b001;
    localparam logic [2:0] COLOR_GREEN = 3'b010;
    localparam logic [2:0] COLOR_RED   = 3'b100;
    localparam logic [2:0] COLOR_WHITE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = DIR_IDLE,
        ST_UP   = DIR_UP,
        ST_DOWN = DIR_DOWN
    } dir_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'b00,
        REQ_UP   = 2'b01,
        REQ_DOWN = 2'b10
    } req_t;

    // Conflicting or absent requests both mean "stop".
    function automatic req_t decode_req(input logic up, input logic down);
        if (up && !down) begin
            return REQ_UP;
        end else if (down && !up) begin
            return REQ_DOWN;
        end
        return REQ_NONE;
    endfunction

    // Every state follows the request directly, so the target depends only on it.
    function automatic dir_t req_to_dir(input req_t req);
        case (req)
            REQ_UP:   return ST_UP;
            REQ_DOWN: return ST_DOWN;
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/paddle_rect_draw.sv
// Combinational rectangle hit test driving an rgb value; shared by paddle and ball.
module paddle_rect_draw #(
    parameter logic [2:0] COLOR = 3'b111
) (
    input  logic [9:0] row,
    input  logic [9:0] col,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic [7:0] size_x,
    input  logic [7:0] size_y,
    output logic [2:0] rgb
);
    import pong_pkg::*;

    logic [10:0] x_end;
    logic [10:0] y_end;
    logic        hit;

    // 11-bit edges so a rectangle touching the last pixel cannot wrap.
    assign x_end = {1'b0, pos_x} + {3'b000, size_x};
    assign y_end = {1'b0, pos_y} + {3'b000, size_y};

    assign hit = (col >= pos_x) && ({1'b0, col} < x_end) &&
                 (row >= pos_y) && ({1'b0, row} < y_end);

    assign rgb = hit ? COLOR : COLOR_BLACK;

endmodule

// File: rtl/paddle_ctrl_gen.sv
// Vertical paddle controller with step/acceleration profile and direction FSM.
// Build macro PADDLE_AI_EN adds ai_mode/ball_y for a ball-tracking opponent.
module paddle_ctrl_gen #(
    parameter logic [2:0] COLOR        = 3'b111,
    parameter int         POS_X        = 5,
    parameter int         START_Y      = 100,
    parameter int         WIDTH        = 8,
    parameter int         HEIGHT       = 65,
    parameter int         LIMIT_MIN    = 5,
    parameter int         LIMIT_MAX    = 475,
    parameter int         STEP         = 1,
    parameter int         PERIOD_START = 5,
    parameter int         PERIOD_MIN   = 2,
    parameter int         ACCEL_STEPS  = 40
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       control_up,
    input  logic       control_down,
`ifdef PADDLE_AI_EN
    input  logic       ai_mode,
    input  logic [9:0] ball_y,
`endif
    input  logic [9:0] row,
    input  logic [9:0] col,
    output logic [2:0] rgb,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [7:0] size_x,
    output logic [7:0] size_y,
    output logic [7:0] speed,
    output logic       at_top,
    output logic       at_bottom,
    output logic [1:0] dir
);
    import pong_pkg::*;

    localparam logic signed [10:0] STEP_S    = 11'(STEP);
    localparam logic signed [10:0] LIM_TOP_S = 11'(LIMIT_MIN);
    localparam logic signed [10:0] LIM_BOT_S = 11'(LIMIT_MAX - HEIGHT);
    localparam logic [7:0]         P_START   = 8'(PERIOD_START);
    localparam logic [7:0]         P_MIN     = 8'(PERIOD_MIN);
    localparam logic [7:0]         A_STEPS   = 8'(ACCEL_STEPS);

    dir_t       dir_reg;
    logic [9:0] pos_y_reg;
    logic [7:0] speed_reg;
    logic [7:0] timer_reg;
    logic [7:0] accel_reg;

    req_t              req;
    dir_t              dir_next;
    logic signed [10:0] pos_s;
    logic signed [10:0] up_pos;
    logic signed [10:0] dn_pos;
    logic signed [10:0] move_pos;
    logic               blocked;
    logic               tick_due;
    logic               accel_wrap;
    logic [7:0]         speed_dec;

`ifdef PADDLE_AI_EN
    localparam logic signed [10:0] DEADBAND = 11'sd4;
    logic signed [10:0] centre_s;
    logic signed [10:0] ball_s;
    req_t               ai_req;

    assign centre_s = pos_s + 11'(HEIGHT / 2);
    assign ball_s   = signed'({1'b0, ball_y});

    always_comb begin
        ai_req = REQ_NONE;
        if (ball_s < centre_s - DEADBAND) begin
            ai_req = REQ_UP;
        end else if (ball_s > centre_s + DEADBAND) begin
            ai_req = REQ_DOWN;
        end
    end

    assign req = ai_mode ? ai_req : decode_req(control_up, control_down);
`else
    assign req = decode_req(control_up, control_down);
`endif

    assign dir_next = req_to_dir(req);
    assign pos_s    = signed'({1'b0, pos_y_reg});

    // Candidate move, clamped against the limit in the current direction.
    always_comb begin
        up_pos = pos_s - STEP_S;
        if (up_pos < LIM_TOP_S) begin
            up_pos = LIM_TOP_S;
        end
        dn_pos = pos_s + STEP_S;
        if (dn_pos > LIM_BOT_S) begin
            dn_pos = LIM_BOT_S;
        end
        if (dir_reg == ST_UP) begin
            move_pos = up_pos;
            blocked  = (up_pos == LIM_TOP_S);
        end else begin
            move_pos = dn_pos;
            blocked  = (dn_pos == LIM_BOT_S);
        end
    end

    assign tick_due   = ({1'b0, timer_reg} + 9'd1) >= {1'b0, speed_reg};
    assign accel_wrap = ({1'b0, accel_reg} + 9'd1) == {1'b0, A_STEPS};
    assign speed_dec  = (speed_reg > P_MIN) ? (speed_reg - 8'd1) : P_MIN;

    always_ff @(posedge clock) begin
        if (reset) begin
            dir_reg   <= ST_IDLE;
            pos_y_reg <= 10'(START_Y);
            speed_reg <= P_START;
            timer_reg <= 8'd0;
            accel_reg <= 8'd0;
        end else if (enable) begin
            if (dir_next != dir_reg) begin
                // Any direction change restarts the acceleration profile.
                dir_reg   <= dir_next;
                speed_reg <= P_START;
                timer_reg <= 8'd0;
                accel_reg <= 8'd0;
            end else if (dir_reg == ST_IDLE) begin
                timer_reg <= 8'd0;
                speed_reg <= P_START;
            end else if (tick_due) begin
                timer_reg <= 8'd0;
                pos_y_reg <= move_pos[9:0];
                if (blocked) begin
                    speed_reg <= P_START;
                    accel_reg <= 8'd0;
                end else if (accel_wrap) begin
                    accel_reg <= 8'd0;
                    speed_reg <= speed_dec;
                end else begin
                    accel_reg <= accel_reg + 8'd1;
                end
            end else begin
                timer_reg <= timer_reg + 8'd1;
            end
        end
    end

    assign pos_x     = 10'(POS_X);
    assign pos_y     = pos_y_reg;
    assign size_x    = 8'(WIDTH);
    assign size_y    = 8'(HEIGHT);
    assign speed     = speed_reg;
    assign dir       = dir_reg;
    assign at_top    = (pos_s == LIM_TOP_S);
    assign at_bottom = ({1'b0, pos_y_reg} + 11'(HEIGHT)) == 11'(LIMIT_MAX);

    paddle_rect_draw #(
        .COLOR(COLOR)
    ) u_draw (
        .row    (row),
        .col    (col),
        .pos_x  (pos_x),
        .pos_y  (pos_y_reg),
        .size_x (size_x),
        .size_y (size_y),
        .rgb    (rgb)
    );

endmodule

// File: tb/tb_paddle_ctrl_gen.sv
// Directed bench for paddle_ctrl_gen: default instance plus a STEP=7 instance near the bottom.
module tb_paddle_ctrl_gen;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       control_up = 1'b0;
    logic       control_down = 1'b0;
    logic [9:0] row = 10'd0;
    logic [9:0] col = 10'd0;
`ifdef PADDLE_AI_EN
    logic       ai_mode = 1'b0;
    logic [9:0] ball_y = 10'd0;
`endif

    logic [2:0] rgb, rgb_b;
    logic [9:0] pos_x, pos_y, pos_x_b, pos_y_b;
    logic [7:0] size_x, size_y, speed, size_x_b, size_y_b, speed_b;
    logic       at_top, at_bottom, at_top_b, at_bottom_b;
    logic [1:0] dir, dir_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    paddle_ctrl_gen dut (
        .clock(clock), .reset(reset), .enable(enable),
        .control_up(control_up), .control_down(control_down),
`ifdef PADDLE_AI_EN
        .ai_mode(ai_mode), .ball_y(ball_y),
`endif
        .row(row), .col(col), .rgb(rgb), .pos_x(pos_x), .pos_y(pos_y),
        .size_x(size_x), .size_y(size_y), .speed(speed),
        .at_top(at_top), .at_bottom(at_bottom), .dir(dir)
    );

    paddle_ctrl_gen #(.START_Y(405), .STEP(7)) dut_b (
        .clock(clock), .reset(reset), .enable(enable),
        .control_up(control_up), .control_down(control_down),
`ifdef PADDLE_AI_EN
        .ai_mode(ai_mode), .ball_y(ball_y),
`endif
        .row(row), .col(col), .rgb(rgb_b), .pos_x(pos_x_b), .pos_y(pos_y_b),
        .size_x(size_x_b), .size_y(size_y_b), .speed(speed_b),
        .at_top(at_top_b), .at_bottom(at_bottom_b), .dir(dir_b)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        control_up = 1'b0; control_down = 1'b0; enable = 1'b1;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        enable = 1'b1;
        checks++; if (pos_y !== 10'd100) begin errors++; $display("FAIL reset_pos_y got %0d exp 100", pos_y); end
        checks++; if (speed !== 8'd5) begin errors++; $display("FAIL reset_speed got %0d exp 5", speed); end
        checks++; if (dir !== 2'b00) begin errors++; $display("FAIL reset_dir got %0d exp 0", dir); end
        checks++; if ({at_top, at_bottom} !== 2'b00) begin errors++; $display("FAIL reset_limits got %b exp 00", {at_top, at_bottom}); end
        checks++; if ({pos_x, size_x, size_y} !== {10'd5, 8'd8, 8'd65}) begin errors++; $display("FAIL reset_geom got x=%0d w=%0d h=%0d exp 5 8 65", pos_x, size_x, size_y); end
        checks++; if (pos_y_b !== 10'd405) begin errors++; $display("FAIL reset_pos_y_b got %0d exp 405", pos_y_b); end
        $display("test_reset done");
    endtask

    task automatic test_geometry();
        row = 10'd100; col = 10'd5; #1;
        checks++; if (rgb !== 3'd7) begin errors++; $display("FAIL rgb_100_5 got %0d exp 7", rgb); end
        row = 10'd165; col = 10'd5; #1;
        checks++; if (rgb !== 3'd0) begin errors++; $display("FAIL rgb_165_5 got %0d exp 0", rgb); end
        row = 10'd100; col = 10'd13; #1;
        checks++; if (rgb !== 3'd0) begin errors++; $display("FAIL rgb_100_13 got %0d exp 0", rgb); end
        row = 10'd164; col = 10'd12; #1;
        checks++; if (rgb !== 3'd7) begin errors++; $display("FAIL rgb_164_12 got %0d exp 7", rgb); end
        row = 10'd99; col = 10'd5; #1;
        checks++; if (rgb !== 3'd0) begin errors++; $display("FAIL rgb_99_5 got %0d exp 0", rgb); end
        row = 10'd120; col = 10'd4; #1;
        checks++; if (rgb !== 3'd0) begin errors++; $display("FAIL rgb_120_4 got %0d exp 0", rgb); end
        $display("test_geometry done");
    endtask

    task automatic test_accel_up();
        do_reset();
        control_up = 1'b1;
        step(1);
        checks++; if (dir !== 2'b01) begin errors++; $display("FAIL up_dir got %0d exp 1", dir); end
        step(4);
        checks++; if (pos_y !== 10'd100) begin errors++; $display("FAIL up_pre_tick got %0d exp 100", pos_y); end
        step(1);
        checks++; if (pos_y !== 10'd99) begin errors++; $display("FAIL up_first_tick got %0d exp 99", pos_y); end
        step(194);
        checks++; if (speed !== 8'd5) begin errors++; $display("FAIL up_speed_39 got %0d exp 5", speed); end
        step(1);
        checks++; if ({pos_y, speed} !== {10'd60, 8'd4}) begin errors++; $display("FAIL up_tick40 got pos=%0d spd=%0d exp 60 4", pos_y, speed); end
        step(160);
        checks++; if ({pos_y, speed} !== {10'd20, 8'd3}) begin errors++; $display("FAIL up_tick80 got pos=%0d spd=%0d exp 20 3", pos_y, speed); end
        $display("test_accel_up done");
    endtask

    task automatic test_reversal();
        control_up = 1'b0; control_down = 1'b1;
        step(1);
        checks++; if ({dir, speed, pos_y} !== {2'b10, 8'd5, 10'd20}) begin errors++; $display("FAIL rev_switch got dir=%0d spd=%0d pos=%0d exp 2 5 20", dir, speed, pos_y); end
        step(4);
        checks++; if (pos_y !== 10'd20) begin errors++; $display("FAIL rev_pre_tick got %0d exp 20", pos_y); end
        step(1);
        checks++; if (pos_y !== 10'd21) begin errors++; $display("FAIL rev_first_tick got %0d exp 21", pos_y); end
        $display("test_reversal done");
    endtask

    task automatic test_top_limit();
        do_reset();
        control_up = 1'b1;
        step(421);
        checks++; if ({pos_y, at_top, speed, dir} !== {10'd5, 1'b1, 8'd5, 2'b01}) begin errors++; $display("FAIL top_limit got pos=%0d top=%0d spd=%0d dir=%0d exp 5 1 5 1", pos_y, at_top, speed, dir); end
        step(30);
        checks++; if ({pos_y, speed} !== {10'd5, 8'd5}) begin errors++; $display("FAIL top_hold got pos=%0d spd=%0d exp 5 5", pos_y, speed); end
        $display("test_top_limit done");
    endtask

    task automatic test_bottom_limit();
        logic [7:0] min_speed;
        do_reset();
        control_down = 1'b1;
        step(1);
        checks++; if (dir !== 2'b10) begin errors++; $display("FAIL down_dir got %0d exp 2", dir); end
        step(5);
        checks++; if ({pos_y_b, at_bottom_b, speed_b} !== {10'd410, 1'b1, 8'd5}) begin errors++; $display("FAIL step7_clamp got pos=%0d bot=%0d spd=%0d exp 410 1 5", pos_y_b, at_bottom_b, speed_b); end
        min_speed = speed;
        for (int i = 0; i < 475; i++) begin
            step(1);
            if (speed < min_speed) min_speed = speed;
        end
        checks++; if ({pos_y, speed} !== {10'd220, 8'd2}) begin errors++; $display("FAIL down_tick120 got pos=%0d spd=%0d exp 220 2", pos_y, speed); end
        for (int i = 0; i < 500; i++) begin
            step(1);
            if (speed < min_speed) min_speed = speed;
        end
        checks++; if ({pos_y, at_bottom, speed, dir} !== {10'd410, 1'b1, 8'd5, 2'b10}) begin errors++; $display("FAIL bottom_limit got pos=%0d bot=%0d spd=%0d dir=%0d exp 410 1 5 2", pos_y, at_bottom, speed, dir); end
        checks++; if (min_speed !== 8'd2) begin errors++; $display("FAIL min_speed got %0d exp 2", min_speed); end
        $display("test_bottom_limit done");
    endtask

    task automatic test_both_and_freeze();
        do_reset();
        control_up = 1'b1;
        step(6);
        control_down = 1'b1;
        step(1);
        checks++; if ({dir, pos_y, speed} !== {2'b00, 10'd99, 8'd5}) begin errors++; $display("FAIL both_req got dir=%0d pos=%0d spd=%0d exp 0 99 5", dir, pos_y, speed); end
        control_down = 1'b0;
        step(4);
        enable = 1'b0;
        step(10);
        checks++; if ({dir, pos_y, speed} !== {2'b01, 10'd99, 8'd5}) begin errors++; $display("FAIL freeze got dir=%0d pos=%0d spd=%0d exp 1 99 5", dir, pos_y, speed); end
        enable = 1'b1;
        step(1);
        checks++; if (pos_y !== 10'd99) begin errors++; $display("FAIL resume_pre got %0d exp 99", pos_y); end
        step(1);
        checks++; if (pos_y !== 10'd98) begin errors++; $display("FAIL resume_tick got %0d exp 98", pos_y); end
        step(2);
        reset = 1'b1;
        step(1);
        checks++; if ({pos_y, speed, dir} !== {10'd100, 8'd5, 2'b00}) begin errors++; $display("FAIL reset_mid got pos=%0d spd=%0d dir=%0d exp 100 5 0", pos_y, speed, dir); end
        reset = 1'b0;
        control_up = 1'b0;
        $display("test_both_and_freeze done");
    endtask

`ifdef PADDLE_AI_EN
    task automatic test_ai();
        do_reset();
        ai_mode = 1'b1; ball_y = 10'd300; control_up = 1'b1;
        step(1);
        checks++; if (dir !== 2'b10) begin errors++; $display("FAIL ai_dir got %0d exp 2", dir); end
        step(700);
        checks++; if ({pos_y, dir} !== {10'd264, 2'b00}) begin errors++; $display("FAIL ai_settle got pos=%0d dir=%0d exp 264 0", pos_y, dir); end
        ai_mode = 1'b0; control_up = 1'b0;
        $display("test_ai done");
    endtask
`endif

    initial begin
        test_reset();
        test_geometry();
        test_accel_up();
        test_reversal();
        test_top_limit();
        test_bottom_limit();
        test_both_and_freeze();
`ifdef PADDLE_AI_EN
        test_ai();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl_gen.md
Name: paddle_ctrl_gen

Overview:
Parametrised successor to the Pong paddle. It is a vertical paddle controller with a configurable step size, a multi-level acceleration profile and an explicit direction state machine. It exports paddle geometry and position to the collision and ball logic, and returns the paddle pixel colour to the VGA pixel mux. One instance is used per player; the AI-driven opponent is an optional build feature.

Parameters:
COLOR, 3'b111, rgb value for paddle pixels
POS_X, 5, fixed left column of the paddle
START_Y, 100, pos_y after reset
WIDTH, 8, paddle width in pixels (1..255)
HEIGHT, 65, paddle height in pixels (1..255)
LIMIT_MIN, 5, smallest legal pos_y
LIMIT_MAX, 475, largest legal pos_y+HEIGHT
STEP, 1, pixels moved per move tick (1..15)
PERIOD_START, 5, enabled cycles per move tick when at rest (2..255)
PERIOD_MIN, 2, fastest period (1..PERIOD_START)
ACCEL_STEPS, 40, move ticks per period decrement (1..255)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
enable  in  1  game-tick qualifier; all state frozen when 0
control_up  in  1  active-high move-up request
control_down  in  1  active-high move-down request
row  in  10  pixel row being drawn
col  in  10  pixel column being drawn
rgb  out  3  COLOR if (row,col) is inside the paddle, else 0
pos_x  out  10  constant POS_X
pos_y  out  10  current top row
size_x  out  8  WIDTH
size_y  out  8  HEIGHT
speed  out  8  current period
at_top  out  1  pos_y==LIMIT_MIN
at_bottom  out  1  pos_y+HEIGHT==LIMIT_MAX
dir  out  2  state: 00 IDLE, 01 UP, 10 DOWN

Behaviour:
- Reset is decided as one clock; reset is synchronous and active-high. The clock port is named clock and the reset port is named reset.
- Reset overrides enable. On reset: pos_y=START_Y, speed=PERIOD_START, timer=0, accel_cnt=0, dir=IDLE. at_top and at_bottom are recomputed from pos_y.
- When enable=0, all registers hold.
- Request decode: req=UP if up&!down; req=DOWN if down&!up; otherwise req=NONE. Both asserted gives NONE.
- FSM transitions on enabled cycles:
  - IDLE->UP/DOWN on a matching req.
  - UP/DOWN->IDLE on NONE.
  - UP<->DOWN directly on a reversed req.
- Any state change, including a direct reversal, forces speed=PERIOD_START, timer=0, accel_cnt=0 in the same cycle.
- In UP or DOWN with no state change: timer increments. When timer+1>=speed, a move tick fires and timer=0.
- Move tick, UP: pos_y=max(pos_y-STEP, LIMIT_MIN).
- Move tick, DOWN: pos_y=min(pos_y+STEP, LIMIT_MAX-HEIGHT).
- All move arithmetic is 11-bit signed, so no wrap occurs.
- If the tick lands on a limit, or the paddle is already at the limit, the paddle is blocked: speed=PERIOD_START and accel_cnt=0. dir keeps the request.
- Unblocked tick: accel_cnt++. When accel_cnt reaches ACCEL_STEPS, accel_cnt=0 and speed=max(speed-1, PERIOD_MIN).
- In IDLE: timer=0, speed=PERIOD_START.
- rgb is combinational, valid in the same cycle as row/col: POS_X<=col<POS_X+WIDTH and pos_y<=row<pos_y+HEIGHT.
- at_top and at_bottom are combinational from registered pos_y.

Optional Feature:
Macro PADDLE_AI_EN.
- Defined: adds inputs ai_mode (1) and ball_y (10). When ai_mode=1, control_up/control_down are ignored. The request is derived as:
  - UP if ball_y < centre-DEADBAND (centre = pos_y+HEIGHT/2, DEADBAND=4 as a localparam);
  - DOWN if ball_y > centre+DEADBAND;
  - otherwise NONE.
- All FSM and acceleration rules apply unchanged.
- Undefined: no extra ports; behaviour is exactly as specified above.

Decomposition:
- Package pong_pkg holds:
  - dir encoding localparams (DIR_IDLE, DIR_UP, DIR_DOWN);
  - screen constants SCREEN_X=640, SCREEN_Y=480;
  - colour constants.
- One natural sub-module, paddle_rect_draw: the combinational rectangle-hit and rgb logic. The ball block reuses it.

Test Plan:
1. Defaults; reset; hold control_up with enable=1 -> after the IDLE->UP cycle, pos_y goes 100->99 five cycles later. speed=4 after 40 ticks and 3 after 80 ticks; it never drops below 2.
2. Hold control_up from pos_y=100 -> pos_y reaches 5 and stays; at_top=1, speed=5, dir=01.
3. Hold control_down -> pos_y stops at 410; at_bottom=1. With STEP=7 from pos_y=405, the next tick gives 410, not 412.
4. Accelerated UP (speed=3), then switch directly to control_down -> dir=10, speed=5 and timer=0 in that cycle; the first down move comes 5 cycles later.
5. up=down=1 -> dir=00, pos_y unchanged. enable=0 mid-move -> all outputs frozen. reset asserted mid-move -> next cycle pos_y=100, speed=5, dir=00.
6. Sweep row/col: (row 100, col 5) gives rgb=7; (row 165, col 5) gives 0; (row 100, col 13) gives 0. With PADDLE_AI_EN, ai_mode=1, ball_y=300 and pos_y=100 -> dir=10 until centre is within ±4 of 300.
